c17_reg: RTL and testbench

- Clocked, pipelined implementation of the ISCAS-85 c17 benchmark: six 2-input NAND gates, 5 inputs, 2 outputs.
- Used as a small reference combinational function with registered outputs and a valid qualifier.
- Used in characterisation/ML data-collection flows that sweep all 32 input patterns.

---
 rtl/c17_pkg.sv | 32 +++
 rtl/c17_reg_nand2.sv | 10 +
 rtl/c17_reg.sv | 88 ++++++++
 tb/tb_c17_reg.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/c17_pkg.sv
// Shared types and golden evaluation function for the registered c17 benchmark.
package c17_pkg;

   localparam int C17_NUM_IN  = 5;
   localparam int C17_NUM_OUT = 2;

   typedef struct packed {
      logic n1;
      logic n2;
      logic n3;
      logic n6;
      logic n7;
   } c17_in_t;

   typedef struct packed {
      logic n22;
      logic n23;
   } c17_out_t;

   function automatic c17_out_t c17_eval(input c17_in_t x);
      logic g10, g11, g16, g19;
      c17_out_t r;
      g10   = ~(x.n1 & x.n3);
      g11   = ~(x.n3 & x.n6);
      g16   = ~(x.n2 & g11);
      g19   = ~(g11 & x.n7);
      r.n22 = ~(g10 & g16);
      r.n23 = ~(g16 & g19);
      return r;
   endfunction

endpackage

// File: rtl/c17_reg_nand2.sv
// Two-input NAND leaf cell used to build the c17 network structurally.
module c17_nand2 (
   input  logic a_i,
   input  logic b_i,
   output logic y_o
);

   assign y_o = ~(a_i & b_i);

endmodule

// File: rtl/c17_reg.sv
// Pipelined c17 benchmark: six-NAND network feeding PIPE_STAGES valid-qualified registers.
// Optional build macro C17_SELFTEST_EN adds an internal 0..31 pattern generator (st_en/st_pat).
module c17_reg
   import c17_pkg::*;
#(
   parameter int PIPE_STAGES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic       n1,
   input  logic       n2,
   input  logic       n3,
   input  logic       n6,
   input  logic       n7,
`ifdef C17_SELFTEST_EN
   input  logic       st_en,
   output logic [4:0] st_pat,
`endif
   output logic       out_valid,
   output logic       n22,
   output logic       n23
);

   c17_in_t  pat_in;
   logic     vld_in;
   c17_out_t res;
   logic     g10, g11, g16, g19;

`ifdef C17_SELFTEST_EN
   logic [C17_NUM_IN-1:0] st_cnt_q, st_cnt_d;

   always_comb begin
      st_cnt_d = st_en ? st_cnt_q + 5'd1 : '0;
      pat_in   = st_en ? c17_in_t'(st_cnt_q) : c17_in_t'({n1, n2, n3, n6, n7});
      vld_in   = st_en | in_valid;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st_cnt_q <= '0;
      else        st_cnt_q <= st_cnt_d;
   end

   assign st_pat = st_cnt_q;
`else
   always_comb begin
      pat_in = c17_in_t'({n1, n2, n3, n6, n7});
      vld_in = in_valid;
   end
`endif

   c17_nand2 u_g10 (.a_i(pat_in.n1), .b_i(pat_in.n3), .y_o(g10));
   c17_nand2 u_g11 (.a_i(pat_in.n3), .b_i(pat_in.n6), .y_o(g11));
   c17_nand2 u_g16 (.a_i(pat_in.n2), .b_i(g11),       .y_o(g16));
   c17_nand2 u_g19 (.a_i(g11),       .b_i(pat_in.n7), .y_o(g19));
   c17_nand2 u_r22 (.a_i(g10),       .b_i(g16),       .y_o(res.n22));
   c17_nand2 u_r23 (.a_i(g16),       .b_i(g19),       .y_o(res.n23));

   logic     [PIPE_STAGES-1:0] vld_q, vld_d;
   c17_out_t [PIPE_STAGES-1:0] dat_q, dat_d;

   // Valid always shifts; data of a stage only moves when its incoming valid is set.
   always_comb begin
      vld_d    = vld_q;
      dat_d    = dat_q;
      vld_d[0] = vld_in;
      dat_d[0] = vld_in ? res : dat_q[0];
      for (int i = 1; i < PIPE_STAGES; i++) begin
         vld_d[i] = vld_q[i-1];
         dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   assign out_valid = vld_q[PIPE_STAGES-1];
   assign n22       = dat_q[PIPE_STAGES-1].n22;
   assign n23       = dat_q[PIPE_STAGES-1].n23;

endmodule

// File: tb/tb_c17_reg.sv
// Self-checking bench for c17_reg at one and four pipeline stages against a history-based model.
module tb_c17_reg;
   import c17_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic in_valid = 1'b0;
   logic n1 = 1'b0, n2 = 1'b0, n3 = 1'b0, n6 = 1'b0, n7 = 1'b0;
   logic ov1, a22, a23, ov4, b22, b23;
   logic [4:0] cur;
`ifdef C17_SELFTEST_EN
   logic st_en = 1'b0;
   logic [4:0] sp1, sp4;
`endif

   int total = 0;
   int bad = 0;

   bit         hv[$];
   logic [1:0] hd[$];
   int         mcnt = 0;

   assign cur = {n1, n2, n3, n6, n7};

   always #5 clk = ~clk;

   c17_reg #(.PIPE_STAGES(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .n1(n1), .n2(n2), .n3(n3), .n6(n6), .n7(n7),
`ifdef C17_SELFTEST_EN
      .st_en(st_en), .st_pat(sp1),
`endif
      .out_valid(ov1), .n22(a22), .n23(a23)
   );

   c17_reg #(.PIPE_STAGES(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .n1(n1), .n2(n2), .n3(n3), .n6(n6), .n7(n7),
`ifdef C17_SELFTEST_EN
      .st_en(st_en), .st_pat(sp4),
`endif
      .out_valid(ov4), .n22(b22), .n23(b23)
   );

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Sum-of-products form of the c17 outputs, bit order {n1,n2,n3,n6,n7}.
   function automatic logic [1:0] ref_eval(input logic [4:0] p);
      logic i1, i2, i3, i6, i7, nand36, e22, e23;
      {i1, i2, i3, i6, i7} = p;
      nand36 = ~(i3 & i6);
      e22 = (i1 & i3) | (i2 & nand36);
      e23 = nand36 & (i2 | i7);
      return {e22, e23};
   endfunction

   // Result for a pipe of depth L: the sample taken L-1 edges ago, data held from last valid.
   task automatic expect_for(input int l, output logic ev, output logic [1:0] ed);
      int idx;
      idx = hv.size() - l;
      ev = 1'b0;
      ed = 2'b00;
      if (idx >= 0) begin
         ev = hv[idx];
         for (int j = idx; j >= 0; j--) begin
            if (hv[j]) begin
               ed = hd[j];
               break;
            end
         end
      end
   endtask

   always begin : compare
      logic [4:0] p;
      logic       v;
      logic       ev;
      logic [1:0] ed;
      @(posedge clk);
      if (!rst_n) begin
         hv.delete();
         hd.delete();
         mcnt = 0;
      end else begin
         p = cur;
         v = in_valid;
`ifdef C17_SELFTEST_EN
         if (st_en) begin
            p = mcnt[4:0];
            v = 1'b1;
            mcnt = (mcnt + 1) % 32;
         end else begin
            mcnt = 0;
         end
`endif
         hv.push_back(v);
         hd.push_back(ref_eval(p));
      end
      #1;
      expect_for(1, ev, ed);
      chk("ov_p1", 8'(ov1), 8'(ev));
      chk("dat_p1", 8'({a22, a23}), 8'(ed));
      expect_for(4, ev, ed);
      chk("ov_p4", 8'(ov4), 8'(ev));
      chk("dat_p4", 8'({b22, b23}), 8'(ed));
`ifdef C17_SELFTEST_EN
      chk("st_pat_p1", 8'(sp1), 8'(mcnt));
      chk("st_pat_p4", 8'(sp4), 8'(mcnt));
`endif
   end

   task automatic drive(input logic [4:0] p, input logic v);
      @(negedge clk);
      {n1, n2, n3, n6, n7} = p;
      in_valid = v;
   endtask

   task automatic apply_chk(input logic [4:0] p, input logic e22, input logic e23);
      drive(p, 1'b1);
      @(posedge clk);
      #1;
      chk("dir_ov", 8'(ov1), 8'd1);
      chk("dir_n22", 8'(a22), 8'(e22));
      chk("dir_n23", 8'(a23), 8'(e23));
   endtask

   initial begin
      for (int p = 0; p < 32; p++) begin
         logic [4:0] pv;
         pv = 5'(p);
         chk("pkg_eval", 8'(c17_eval(pv)), 8'(ref_eval(pv)));
      end
      chk("model_00000", 8'(ref_eval(5'b00000)), 8'b00);
      chk("model_11111", 8'(ref_eval(5'b11111)), 8'b10);
      chk("model_01000", 8'(ref_eval(5'b01000)), 8'b11);
      chk("model_00001", 8'(ref_eval(5'b00001)), 8'b01);

      #1 rst_n = 1'b0;
      #1;
      chk("rst_ov1", 8'(ov1), 8'd0);
      chk("rst_dat1", 8'({a22, a23}), 8'd0);
      chk("rst_ov4", 8'(ov4), 8'd0);
      chk("rst_dat4", 8'({b22, b23}), 8'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      apply_chk(5'b00000, 1'b0, 1'b0);
      apply_chk(5'b11111, 1'b1, 1'b0);
      apply_chk(5'b01000, 1'b1, 1'b1);
      apply_chk(5'b00001, 1'b0, 1'b1);
      apply_chk(5'b10100, 1'b1, 1'b0);
      chk("p4_latency", 8'({ov4, b22, b23}), 8'b110);

      drive(5'b11111, 1'b1);
      repeat (3) begin
         drive(5'b00000, 1'b0);
         @(posedge clk);
         #1;
         chk("bubble", 8'({ov1, a22, a23}), 8'b010);
      end

      for (int r = 0; r < 3; r++)
         for (int p = 0; p < 32; p++)
            drive(5'(p), 1'b1);

      repeat (4) drive(5'b11111, 1'b1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_p1", 8'({ov1, a22, a23}), 8'd0);
      chk("midrst_p4", 8'({ov4, b22, b23}), 8'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_p1", 8'({ov1, a22, a23}), 8'b110);
      chk("post_rst_p4", 8'(ov4), 8'd0);
      repeat (6) drive(5'b11111, 1'b1);

`ifdef C17_SELFTEST_EN
      drive(5'b10101, 1'b0);
      st_en = 1'b1;
      repeat (40) @(negedge clk);
      chk("st_after40", 8'(sp1), 8'd8);
      st_en = 1'b0;
      @(posedge clk);
      #1;
      chk("st_cleared", 8'(sp1), 8'd0);
`endif

      drive(5'b00000, 1'b0);
      repeat (6) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
